// File: rtl/rogelio_mv_pkg.sv
// Shared opcode encodings and pin-direction constants for the rogelio_mv accumulator ALU.
package rogelio_mv_pkg;

    localparam int unsigned WIDTH = 8;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_SHR  = 3'd7;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

endpackage

// File: rtl/rogelio_mv_alu.sv
// Combinational ALU: computes the next accumulator value and carry/borrow for one opcode.
module rogelio_mv_alu
    import rogelio_mv_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] r,
    output logic             c
);

    logic [WIDTH:0] wide;

    always_comb begin
        r    = '0;
        c    = 1'b0;
        wide = '0;
        case (op)
            OP_LOAD: r = b;
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
            end
            // Bit 8 of the 9-bit difference is set exactly when b > a (borrow).
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: begin
                r = {a[WIDTH-2:0], 1'b0};
                c = a[WIDTH-1];
            end
            OP_SHR: begin
                r = {1'b0, a[WIDTH-1:1]};
                c = a[0];
            end
            default: begin
                r = '0;
                c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rogelio_mv.sv
// Tiny Tapeout accumulator ALU: executes one command per rising edge of the uio_in[3] strobe.
module rogelio_mv
    import rogelio_mv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] ui_in,
    input  logic [7:0]       uio_in,
    output logic [WIDTH-1:0] uo_out,
    output logic [7:0]       uio_out,
    output logic [7:0]       uio_oe
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             n_q, n_d;
    logic             done_q, done_d;
    logic             strobe_q;
    logic             fire;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             unused_uio;

    assign unused_uio = ^uio_in[7:4];

    rogelio_mv_alu u_alu (
        .a  (acc_q),
        .b  (ui_in),
        .op (uio_in[2:0]),
        .r  (alu_r),
        .c  (alu_c)
    );

    // strobe_q resets high so a strobe held through reset release is not seen as an edge.
    assign fire = ena & uio_in[3] & ~strobe_q;

    always_comb begin
        acc_d  = acc_q;
        z_d    = z_q;
        c_d    = c_q;
        n_d    = n_q;
        done_d = 1'b0;
        if (fire) begin
            acc_d  = alu_r;
            z_d    = (alu_r == '0);
            c_d    = alu_c;
            n_d    = alu_r[WIDTH-1];
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            z_q      <= 1'b1;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= 1'b1;
        end else begin
            acc_q    <= acc_d;
            z_q      <= z_d;
            c_q      <= c_d;
            n_q      <= n_d;
            done_q   <= done_d;
            strobe_q <= uio_in[3];
        end
    end

    assign uo_out  = acc_q;
    assign uio_out = {done_q, n_q, c_q, z_q, 4'b0000};
    assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_rogelio_mv.sv
// Self-checking bench for rogelio_mv: directed vector table, edge-rule sequences, random vs model.
module tb_rogelio_mv;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_acc;
    bit m_z, m_c, m_n, m_done, m_prev;

    typedef struct {
        logic [2:0] op;
        logic [7:0] b;
        logic [7:0] exp_acc;
        logic [7:0] exp_uio;
    } vec_t;

    vec_t vecs[14];

    rogelio_mv dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] flags_byte(input bit done, input bit n, input bit c, input bit z);
        return {done, n, c, z, 4'b0000};
    endfunction

    // Reference results from plain integer arithmetic.
    task automatic ref_exec(input int op, input int a, input int b, output int r, output bit c);
        c = 1'b0;
        case (op)
            0: r = b;
            1: begin r = (a + b) % 256; c = (a + b) > 255; end
            2: begin r = (a - b + 256) % 256; c = b > a; end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: begin r = (a * 2) % 256; c = a >= 128; end
            default: begin r = a / 2; c = (a % 2) == 1; end
        endcase
    endtask

    task automatic model_reset();
        m_acc = 0; m_z = 1; m_c = 0; m_n = 0; m_done = 0; m_prev = 1;
    endtask

    // Advance one clock, update the model from the inputs present at the edge, compare after #1.
    task automatic cycle(input string tag);
        int r;
        bit c;
        @(posedge clk);
        if (ena && uio_in[3] && !m_prev) begin
            ref_exec(int'(uio_in[2:0]), m_acc, int'(ui_in), r, c);
            m_acc = r; m_z = (r == 0); m_n = (r >= 128); m_c = c; m_done = 1;
        end else begin
            m_done = 0;
        end
        m_prev = uio_in[3];
        #1;
        check({tag, ".acc"}, uo_out, 8'(m_acc));
        check({tag, ".uio"}, uio_out, flags_byte(m_done, m_n, m_c, m_z));
    endtask

    task automatic set_cmd(input bit strobe, input logic [2:0] op, input logic [7:0] b);
        uio_in = {4'b0000, strobe, op};
        ui_in  = b;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 8'h7F, 8'h7F, 8'h80};
        vecs[1]  = '{3'd1, 8'h01, 8'h80, 8'hC0};
        vecs[2]  = '{3'd1, 8'h80, 8'h00, 8'hB0};
        vecs[3]  = '{3'd0, 8'h05, 8'h05, 8'h80};
        vecs[4]  = '{3'd2, 8'h06, 8'hFF, 8'hE0};
        vecs[5]  = '{3'd2, 8'hFF, 8'h00, 8'h90};
        vecs[6]  = '{3'd0, 8'h81, 8'h81, 8'hC0};
        vecs[7]  = '{3'd6, 8'h55, 8'h02, 8'hA0};
        vecs[8]  = '{3'd7, 8'h55, 8'h01, 8'h80};
        vecs[9]  = '{3'd7, 8'h55, 8'h00, 8'hB0};
        vecs[10] = '{3'd0, 8'hF0, 8'hF0, 8'hC0};
        vecs[11] = '{3'd3, 8'h3C, 8'h30, 8'h80};
        vecs[12] = '{3'd4, 8'h0F, 8'h3F, 8'h80};
        vecs[13] = '{3'd5, 8'h3F, 8'h00, 8'h90};

        // Reset with strobe held high; release must not fire.
        rst_n = 1'b0;
        ena   = 1'b1;
        set_cmd(1'b1, 3'd0, 8'hAA);
        model_reset();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        cycle("reset_release");
        check("reset.uo_out", uo_out, 8'h00);
        check("reset.uio_out", uio_out, 8'h10);
        check("reset.uio_oe", uio_oe, 8'hF0);
        set_cmd(1'b0, 3'd0, 8'h00);
        cycle("reset_idle");

        // Directed table: strobe one cycle, then low one cycle.
        for (int i = 0; i < 14; i++) begin
            set_cmd(1'b1, vecs[i].op, vecs[i].b);
            cycle($sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_acc", i), uo_out, vecs[i].exp_acc);
            check($sformatf("vec%0d.tbl_uio", i), uio_out, vecs[i].exp_uio);
            set_cmd(1'b0, vecs[i].op, vecs[i].b);
            cycle($sformatf("vec%0d_low", i));
            check($sformatf("vec%0d.tbl_hold", i), uio_out, vecs[i].exp_uio & 8'h7F);
        end

        // Strobe held 5 cycles with ADD 1 from ACC=0: one execution, DONE for one cycle.
        set_cmd(1'b1, 3'd0, 8'h00);
        cycle("held_load");
        set_cmd(1'b0, 3'd0, 8'h00);
        cycle("held_gap");
        set_cmd(1'b1, 3'd1, 8'h01);
        for (int i = 0; i < 5; i++) begin
            cycle($sformatf("held%0d", i));
            check($sformatf("held%0d.done", i), uio_out[7], (i == 0) ? 8'h01 : 8'h00);
        end
        check("held.acc", uo_out, 8'h01);
        set_cmd(1'b0, 3'd1, 8'h01);
        cycle("held_end");

        // ena low during the edge: lost, and not recovered when ena returns with strobe still high.
        ena = 1'b0;
        set_cmd(1'b1, 3'd1, 8'h10);
        cycle("ena_off");
        check("ena_off.acc", uo_out, 8'h01);
        ena = 1'b1;
        cycle("ena_back");
        check("ena_back.acc", uo_out, 8'h01);
        check("ena_back.done", uio_out[7], 8'h00);
        set_cmd(1'b0, 3'd1, 8'h10);
        cycle("ena_low");

        // Back-to-back strobe 1,0,1 executes twice on the running ACC.
        set_cmd(1'b1, 3'd1, 8'h03);
        cycle("b2b_a");
        set_cmd(1'b0, 3'd1, 8'h03);
        cycle("b2b_gap");
        set_cmd(1'b1, 3'd1, 8'h03);
        cycle("b2b_b");
        check("b2b.acc", uo_out, 8'h07);
        set_cmd(1'b0, 3'd1, 8'h03);
        cycle("b2b_end");

        // Async reset between edges.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async.uo_out", uo_out, 8'h00);
        check("async.uio_out", uio_out, 8'h10);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("async_release");

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            ena    = ($urandom_range(0, 7) != 0);
            uio_in = 8'($urandom);
            ui_in  = 8'($urandom);
            cycle($sformatf("rand%0d", i));
        end
        check("final.uio_oe", uio_oe, 8'hF0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
